// File: rtl/lfsr_rr_sched.sv
// Shares one Fibonacci LFSR among NREQ round-robin requesters and sequences seed loads.
// Optional macro LFSR_LOCKUP_FIX_EN: substitute SEED for an all-zero state and pulse o_lockup.
module lfsr_rr_sched #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b110,
  parameter logic [WIDTH-1:0] SEED  = 3'b001,
  parameter int               NREQ  = 2
) (
  input  logic             i_clk,
  input  logic             i_set,
  input  logic             i_seed_ld,
  input  logic [WIDTH-1:0] i_seed_val,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_gnt,
  output logic [WIDTH-1:0] o_rnd,
  output logic             o_rnd_valid,
  output logic             o_busy,
  output logic             o_lockup
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lfsr, r_seed;
  logic             r_pend;
  logic [NREQ-1:0]  r_req;
  logic [PW-1:0]    r_ptr;

  logic             w_pend;
  logic             w_grant;
  logic             w_win_any;
  logic [NREQ-1:0]  w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_step_val;

  assign w_pend = r_pend | i_seed_ld;
  assign w_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};

  // Winner is the first registered request found after the last granted index.
  always_comb begin
    logic [PW:0] sum;
    sum       = '0;
    w_win_any = 1'b0;
    w_win_oh  = '0;
    w_win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!w_win_any && r_req[sum[PW-1:0]]) begin
        w_win_any           = 1'b1;
        w_win_oh[sum[PW-1:0]] = 1'b1;
        w_win_idx           = sum[PW-1:0];
      end
    end
  end

  assign w_grant = (r_state == ST_GRANT) && w_win_any;

`ifdef LFSR_LOCKUP_FIX_EN
  logic r_lockup;
  logic w_lock_evt;

  always_comb begin
    w_load_val = (r_seed == '0) ? SEED : r_seed;
    w_step_val = (r_lfsr == '0) ? SEED : w_step;
    w_lock_evt = ((r_state == ST_LOAD) && (r_seed == '0)) || (w_grant && (r_lfsr == '0));
  end

  always_ff @(posedge i_clk) begin
    if (i_set) r_lockup <= 1'b0;
    else       r_lockup <= w_lock_evt;
  end

  assign o_lockup = r_lockup;
`else
  always_comb begin
    w_load_val = r_seed;
    w_step_val = w_step;
  end

  assign o_lockup = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_set) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pend)      w_state_nxt = ST_LOAD;
        else if (|i_req) w_state_nxt = ST_GRANT;
        else             w_state_nxt = ST_IDLE;
      end
      ST_LOAD:  w_state_nxt = (|i_req) ? ST_GRANT : ST_IDLE;
      ST_GRANT: begin
        if (!w_win_any)                 w_state_nxt = ST_IDLE;
        else if (w_pend)                w_state_nxt = ST_LOAD;
        else if (|(i_req & ~w_win_oh))  w_state_nxt = ST_GRANT;
        else                            w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_gnt       = w_grant ? w_win_oh : '0;
    o_rnd_valid = w_grant;
    o_busy      = (r_state != ST_IDLE) || r_pend;
    o_rnd       = r_lfsr;
  end

  // A seed strobe arriving during LOAD overwrites the latch and stays pending.
  always_ff @(posedge i_clk) begin
    if (i_set) begin
      r_lfsr <= SEED;
      r_seed <= '0;
      r_pend <= 1'b0;
      r_req  <= '0;
      r_ptr  <= PW'(NREQ - 1);
    end else begin
      r_req <= i_req;
      if (i_seed_ld) begin
        r_seed <= i_seed_val;
        r_pend <= 1'b1;
      end else if (r_state == ST_LOAD) begin
        r_pend <= 1'b0;
      end
      if (r_state == ST_LOAD) begin
        r_lfsr <= w_load_val;
      end else if (w_grant) begin
        r_lfsr <= w_step_val;
        r_ptr  <= w_win_idx;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched: grants checked against a queue of expected (gnt, rnd) pairs.
module tb_lfsr_rr_sched;

`ifdef LFSR_LOCKUP_FIX_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       set, seed_ld;
  logic [2:0] seed_val, rnd;
  logic [1:0] req, gnt;
  logic       rnd_valid, busy, lockup;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] g;
    logic [2:0] r;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  lfsr_rr_sched #(.WIDTH(3), .TAPS(3'b110), .SEED(3'b001), .NREQ(2)) dut (
    .i_clk      (clk),
    .i_set      (set),
    .i_seed_ld  (seed_ld),
    .i_seed_val (seed_val),
    .i_req      (req),
    .o_gnt      (gnt),
    .o_rnd      (rnd),
    .o_rnd_valid(rnd_valid),
    .o_busy     (busy),
    .o_lockup   (lockup)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  function automatic logic [2:0] lfsr_nxt(input logic [2:0] s);
    return {s[1:0], s[2] ^ s[1]};
  endfunction

  // Scoreboard side: every valid word must match the next queued expectation.
  always @(negedge clk) begin
    if (rnd_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_grant", 32'(gnt), 32'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(e.g));
        chk("sb_rnd", 32'(rnd), 32'(e.r));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] m;
    set = 1'b1; seed_ld = 1'b0; seed_val = '0; req = '0;

    // Reset state
    step; step;
    set = 1'b0;
    samp;
    chk("rst_gnt",    32'(gnt),       32'(0));
    chk("rst_valid",  32'(rnd_valid), 32'(0));
    chk("rst_rnd",    32'(rnd),       32'(3'b001));
    chk("rst_busy",   32'(busy),      32'(0));
    chk("rst_lockup", 32'(lockup),    32'(0));

    // Single requester: one-cycle latency, then the next word
    step; req = 2'b01; sbq.push_back('{2'b01, 3'b001}); samp;
    chk("t1_idle_gnt", 32'(gnt), 32'(0));
    step; samp;
    chk("t1_latency_gnt", 32'(gnt), 32'(2'b01));
    chk("t1_valid", 32'(rnd_valid), 32'(1));
    step; req = 2'b00; samp;
    chk("t1_after_gnt", 32'(gnt), 32'(0));
    step; req = 2'b01; sbq.push_back('{2'b01, 3'b010}); samp;
    step; samp;
    chk("t1_gnt2", 32'(gnt), 32'(2'b01));
    step; req = 2'b00; set = 1'b1;

    // Two competing requesters: back-to-back alternating grants over a full period
    step; set = 1'b0; req = 2'b11; samp;
    chk("t2_idle_gnt", 32'(gnt), 32'(0));
    m = 3'b001;
    for (int i = 0; i < 8; i++) begin
      sbq.push_back('{((i % 2) == 0) ? 2'b01 : 2'b10, m});
      m = lfsr_nxt(m);
    end
    for (int i = 0; i < 8; i++) begin
      step;
      if (i == 7) req = 2'b00;
      samp;
      chk("t2_b2b_valid", 32'(rnd_valid), 32'(1));
    end
    step; samp;
    chk("t2_idle_after", 32'(rnd_valid), 32'(0));

    // Seed load in IDLE beats a simultaneous request
    step; seed_ld = 1'b1; seed_val = 3'b101; req = 2'b10;
    sbq.push_back('{2'b10, 3'b101}); samp;
    chk("t3_idle_gnt", 32'(gnt), 32'(0));
    step; seed_ld = 1'b0; samp;
    chk("t3_load_gnt",   32'(gnt),       32'(0));
    chk("t3_load_busy",  32'(busy),      32'(1));
    chk("t3_load_valid", 32'(rnd_valid), 32'(0));
    step; req = 2'b00; samp;
    chk("t3_gnt", 32'(gnt), 32'(2'b10));
    step; samp;
    chk("t3_idle_busy", 32'(busy), 32'(0));

    // Seed strobe during a grant: grant completes, LOAD follows, then the new seed
    step; req = 2'b01;
    sbq.push_back('{2'b01, 3'b011});
    sbq.push_back('{2'b01, 3'b011}); samp;
    step; seed_ld = 1'b1; seed_val = 3'b011; samp;
    chk("t4_gnt_during_seed", 32'(gnt), 32'(2'b01));
    step; seed_ld = 1'b0; samp;
    chk("t4_load_gnt",  32'(gnt),  32'(0));
    chk("t4_load_busy", 32'(busy), 32'(1));
    step; req = 2'b00; samp;
    chk("t4_gnt_after_load", 32'(gnt), 32'(2'b01));
    step; samp;

    // Reset in a GRANT cycle drops the grant and restores priority to requester 0
    step; req = 2'b11; sbq.push_back('{2'b10, 3'b111}); samp;
    step; set = 1'b1; req = 2'b00; samp;
    chk("t5_gnt_before_rst", 32'(gnt), 32'(2'b10));
    step; set = 1'b0; req = 2'b11; sbq.push_back('{2'b01, 3'b001}); samp;
    chk("t5_rst_gnt",   32'(gnt),       32'(0));
    chk("t5_rst_valid", 32'(rnd_valid), 32'(0));
    chk("t5_rst_rnd",   32'(rnd),       32'(3'b001));
    chk("t5_rst_busy",  32'(busy),      32'(0));
    step; req = 2'b00; samp;
    chk("t5_first_gnt", 32'(gnt), 32'(2'b01));
    step; samp;

    // Zero seed: stuck at zero by default, replaced by SEED with the lockup fix
    step; seed_ld = 1'b1; seed_val = 3'b000; req = 2'b01;
    sbq.push_back('{2'b01, FIX ? 3'b001 : 3'b000}); samp;
    step; seed_ld = 1'b0; samp;
    chk("t6_load_lockup", 32'(lockup), 32'(0));
    step; req = 2'b00; samp;
    chk("t6_lockup_pulse", 32'(lockup), 32'(FIX));
    chk("t6_gnt", 32'(gnt), 32'(2'b01));
    step; samp;
    chk("t6_lockup_clear", 32'(lockup), 32'(0));
    step; req = 2'b01; sbq.push_back('{2'b01, FIX ? 3'b010 : 3'b000}); samp;
    step; req = 2'b00; samp;
    chk("t6_gnt2", 32'(gnt), 32'(2'b01));
    step; step; samp;
    chk("sb_drained", 32'(sbq.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
